// File: rtl/uart_link.sv
// Full-duplex UART with configurable framing and a receive FIFO carrying sticky error flags.
// TX and RX run independent bit-timing counters derived from CLK_FREQ/BAUD.
module uart_link #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rxd,
    output logic                          uart_txd,
    input  logic                          we,
    input  logic [DATA_BITS-1:0]          send_data,
    input  logic                          re,
    output logic [DATA_BITS-1:0]          receive_data,
    output logic                          tx_busy,
    output logic [$clog2(RX_DEPTH):0]     rx_count,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic                          rx_overrun,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err
);

    localparam int DIV    = CLK_FREQ / BAUD;
    localparam int CNT_W  = $clog2(STOP_BITS * DIV + 1);
    localparam int PTR_W  = $clog2(RX_DEPTH);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * DIV - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(RX_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;

    always_ff @(posedge clk) begin
        if (tx_state == S_IDLE && we)
            tx_shreg <= send_data;
        else if (tx_state == S_DATA && tx_cnt == BIT_END)
            tx_shreg <= tx_shreg >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= '0;
                    if (we) begin
                        tx_par   <= par_bit(send_data);
                        tx_state <= S_START;
                        uart_txd <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                S_START: if (tx_cnt == BIT_END) begin
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                    tx_state <= S_DATA;
                    uart_txd <= tx_shreg[0];
                end
                S_DATA: if (tx_cnt == BIT_END) begin
                    tx_cnt <= '0;
                    if (tx_bit == LAST_BIT) begin
                        tx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        uart_txd <= (PARITY != 0) ? tx_par : 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 1'b1;
                        uart_txd <= tx_shreg[1];
                    end
                end
                S_PARITY: if (tx_cnt == BIT_END) begin
                    tx_cnt   <= '0;
                    tx_state <= S_STOP;
                    uart_txd <= 1'b1;
                end
                S_STOP: if (tx_cnt == STOP_END) begin
                    tx_state <= S_IDLE;
                    tx_busy  <= 1'b0;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_s1, rx_s2, rx_prev;
    logic [2:0]           rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_par;
    logic                 push_ev, ferr_ev, perr_ev, par_bad;

    assign par_bad = (PARITY != 0) && (rx_par != par_bit(rx_shreg));

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_cnt == BIT_END)
            rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rx_s1, rx_s2, rx_prev} <= 3'b111;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_par   <= 1'b0;
            push_ev  <= 1'b0;
            ferr_ev  <= 1'b0;
            perr_ev  <= 1'b0;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_cnt  <= rx_cnt + 1'b1;
            push_ev <= 1'b0;
            ferr_ev <= 1'b0;
            perr_ev <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_state <= S_START;
                end
                // a line that is high again at mid-start was only a glitch
                S_START: if (rx_cnt == HALF_END) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_cnt == BIT_END) begin
                    rx_cnt <= '0;
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == LAST_BIT) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (rx_cnt == BIT_END) begin
                    rx_cnt   <= '0;
                    rx_par   <= rx_s2;
                    rx_state <= S_STOP;
                end
                S_STOP: if (rx_cnt == BIT_END) begin
                    rx_state <= S_IDLE;
                    ferr_ev  <= ~rx_s2;
                    push_ev  <= rx_s2;
                    perr_ev  <= rx_s2 & par_bad;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic [DATA_BITS-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 pop, push_ok, ovr_ev;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign pop      = re && !rx_empty;
    assign push_ok  = push_ev && (!rx_full || pop);
    assign ovr_ev   = push_ev && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rx_count      <= '0;
            receive_data  <= '0;
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                receive_data <= mem[rd_ptr];
            end
            if (push_ok && !pop)      rx_count <= rx_count + 1'b1;
            else if (pop && !push_ok) rx_count <= rx_count - 1'b1;
            // a new error in the same cycle as a pop keeps its flag set
            rx_overrun    <= ovr_ev  | (rx_overrun    & ~pop);
            rx_frame_err  <= ferr_ev | (rx_frame_err  & ~pop);
            rx_parity_err <= perr_ev | (rx_parity_err & ~pop);
        end
    end

endmodule
